// File: rtl/layer_stream_pkg.sv
// Shared types for the layer output streaming path: serializer FSM states
// and the index-width helper.
package layer_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Index width for an n-element vector, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_vector_serializer.sv
// Streams a captured dataWidth*neuron_no vector out one element per valid/ready
// handshake. Define SERIALIZER_DOUBLE_BUFFER_EN for a shadow buffer that chains vectors.
module layer_vector_serializer
  import layer_stream_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int neuron_no = 20,
  localparam int IW = idx_width(neuron_no),
  localparam int VW = dataWidth * neuron_no
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [VW-1:0]        in,
  input  logic                 load,
  output logic                 load_ready,
  output logic [dataWidth-1:0] out_data,
  output logic [IW-1:0]        out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 done,
  output logic                 fsm_state
);

  // Handshake: an element moves when out_valid & out_ready on a rising edge;
  // a vector is captured when load & load_ready. Outputs hold while stalled.

  localparam logic [IW-1:0] LAST_IDX = IW'(neuron_no - 1);

  state_t        state_q, state_d;
  logic [VW-1:0] buf_q, buf_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          load_acc, xfer, at_last;

`ifdef SERIALIZER_DOUBLE_BUFFER_EN
  logic [VW-1:0] shadow_q, shadow_d;
  logic          pend_q, pend_d;
  assign load_ready = ~pend_q;
`else
  assign load_ready = (state_q == IDLE);
`endif

  assign load_acc  = load & load_ready;
  assign xfer      = (state_q == STREAM) & out_ready;
  assign at_last   = (idx_q == LAST_IDX);

  assign out_valid = (state_q == STREAM);
  assign out_index = idx_q;
  assign out_last  = (state_q == STREAM) & at_last;
  assign out_data  = (state_q == STREAM) ? buf_q[int'(idx_q)*dataWidth +: dataWidth] : '0;
  assign done      = done_q;
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
    shadow_d = shadow_q;
    pend_d   = pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_acc) begin
          buf_d   = in;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
            // A vector waiting (or arriving right now) follows with no bubble.
            if (pend_q) begin
              buf_d   = shadow_q;
              pend_d  = 1'b0;
              state_d = STREAM;
            end else if (load_acc) begin
              buf_d   = in;
              state_d = STREAM;
            end
`endif
          end
        end
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
        if (load_acc && !(xfer && at_last)) begin
          shadow_d = in;
          pend_d   = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
      shadow_q <= '0;
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_layer_vector_serializer.sv
// Scoreboard bench for layer_vector_serializer (4 x 16-bit vectors); the model
// treats the output as a FIFO of accepted vectors' elements.
module tb_layer_vector_serializer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;
  localparam int EW = W + IW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*W-1:0] vec_in;
  logic          load;
  logic          load_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic          fsm_state;

  layer_vector_serializer #(.dataWidth(W), .neuron_no(N)) dut (
    .clk(clk), .rst_n(rst_n), .in(vec_in), .load(load), .load_ready(load_ready),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .done(done), .fsm_state(fsm_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // scoreboard state: {last, index, data} of every element still owed
  logic [EW-1:0] exp_q[$];
  logic          exp_done = 1'b0;
  logic          prev_rst_low = 1'b0;
  int            checks = 0;
  int            passes = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // monitor: samples on the falling edge, inputs are stable since posedge+1
  always @(negedge clk) begin
    logic [EW-1:0] head;
    logic          exp_valid, exp_lr;
    int            sz;
    sz        = exp_q.size();
    exp_valid = (sz > 0);
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
    exp_lr = (sz <= N);
`else
    exp_lr = (sz == 0);
`endif
    head = exp_valid ? exp_q[0] : '0;
    chk("load_ready", load_ready, exp_lr);
    chk("out_valid", out_valid, exp_valid);
    chk("fsm_state", fsm_state, exp_valid);
    chk("done", done, exp_done);
    if (prev_rst_low) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_out_index", out_index, 0);
    end
    if (exp_valid) begin
      chk("out_data", out_data, head[W-1:0]);
      chk("out_index", out_index, head[W+IW-1:W]);
      chk("out_last", out_last, head[EW-1]);
    end else begin
      chk("idle_out_last", out_last, 0);
    end
    exp_done = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      prev_rst_low = 1'b1;
    end else begin
      prev_rst_low = 1'b0;
      if (exp_valid && out_ready) begin
        void'(exp_q.pop_front());
        if (head[EW-1]) exp_done = 1'b1;
      end
      if (load && exp_lr) begin
        for (int k = 0; k < N; k++)
          exp_q.push_back({(k == N-1), IW'(k), vec_in[k*W +: W]});
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [N*W-1:0] v);
    vec_in = v;
    load   = 1'b1;
    cyc();
    load   = 1'b0;
    vec_in = {$urandom, $urandom};
  endtask

  localparam logic [N*W-1:0] V1 = 64'h0004_0003_0002_0001;
  localparam logic [N*W-1:0] V2 = 64'h0008_0007_0006_0005;
  localparam logic [N*W-1:0] V3 = 64'h000c_000b_000a_0009;

  initial begin
    rst_n = 1'b0; load = 1'b0; out_ready = 1'b1; vec_in = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // plain stream at full rate
    pulse_load(V1);
    repeat (8) cyc();

    // downstream stall on element 1 for three cycles
    pulse_load(V1);
    cyc();
    out_ready = 1'b0;
    repeat (3) cyc();
    out_ready = 1'b1;
    repeat (8) cyc();

    // load while streaming, then a third load while one is pending
    pulse_load(V1);
    cyc();
    pulse_load(V2);
    pulse_load(V3);
    repeat (14) cyc();

    // load exactly in the done cycle
    pulse_load(V1);
    repeat (4) cyc();
    pulse_load(V2);
    repeat (10) cyc();

    // reset mid-stream with a second vector possibly pending
    pulse_load(V1);
    pulse_load(V2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();

    // randomized traffic with occasional stalls, loads and resets
    for (int i = 0; i < 600; i++) begin
      load      = ($urandom_range(0, 4) == 0);
      vec_in    = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      cyc();
    end

    // drain
    load = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
    chk("drain_timeout", exp_q.size(), 0);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
